udp_tx_frame_buffer: RTL and testbench
======================================

# udp_tx_frame_buffer

Store-and-forward byte FIFO between the register-control block's UDP TX payload stream and the UDP stack's TX payload input. Each response frame is buffered in full and released only after its `tlast` byte is written, so the UDP stack never sees a partial payload. A frame that overflows the buffer is discarded whole and counted. Output runs at one byte per clock.

## Interface
- `DEPTH`, default 2048: buffer size in bytes; power of two, ≥ 16.
- `DROP_CNT_W`, default 16: width of the drop counter.

- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low (one clock, async active-low reset).
- `i_in_axis_tdata`  in  8  payload byte from register control.
- `i_in_axis_tvalid`  in  1  input byte valid.
- `i_in_axis_tlast`  in  1  last byte of the input frame.
- `o_in_axis_tready`  out  1  input ready; 0 in reset, 1 from the first clock edge after reset release.
- `o_out_axis_tdata`  out  8  payload byte to the UDP stack.
- `o_out_axis_tvalid`  out  1  output byte valid.
- `o_out_axis_tlast`  out  1  last byte of the output frame.
- `i_out_axis_tready`  in  1  UDP stack ready.
- `o_frames_pending`  out  $clog2(DEPTH)+1  number of committed frames not yet fully sent.
- `o_drop_count`  out  DROP_CNT_W  number of dropped frames; saturating.
- `o_overflow`  out  1  one-cycle pulse when a frame is marked for drop.

## Operation
- **Storage.** 9-bit entries `{tlast, tdata}` in a simple dual-port RAM with 1-cycle synchronous read.
- **Pointers.** `wr_ptr` (speculative), `commit_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - Used space = `wr_ptr - rd_ptr`, modulo 2^(W).
  - Full when used space == DEPTH.
- **Write FSM** has states `IDLE`, `FILL` and `DROP`. A handshake is `i_in_axis_tvalid & o_in_axis_tready`.
  - `IDLE`/`FILL`, not full: write the byte and increment `wr_ptr`.
    - If `tlast`: `commit_ptr <= wr_ptr+1`, `o_frames_pending` +1, go to `IDLE`.
    - Otherwise go to `FILL`.
  - `IDLE`/`FILL`, full: do not write. Rewind `wr_ptr <= commit_ptr`, pulse `o_overflow`, increment `o_drop_count` (saturating).
    - If the byte has `tlast`: go to `IDLE` (the frame is finished and dropped).
    - Otherwise go to `DROP`.
  - `DROP`: discard every byte. On `tlast` go to `IDLE`; the next byte starts a new frame.
- **Ready.** `o_in_axis_tready` stays 1 outside reset. Upstream is never stalled; overflow is resolved by dropping.
- **Read side.**
  - Reads only entries below `commit_ptr`.
  - A prefetch path (RAM read stage plus 2-entry output skid) sustains 1 byte/cycle while `i_out_axis_tready` = 1.
  - Holds data and `tlast` stable while `tvalid` = 1 and `tready` = 0.
- **Frame count.** `o_frames_pending` decrements on an output handshake with `tlast`. Simultaneous increment and decrement leaves it unchanged.

## Timing
- **Reset values:**
  - `o_out_axis_tvalid`, `o_out_axis_tlast`, `o_out_axis_tdata`, `o_in_axis_tready`, `o_overflow`: 0.
  - `o_frames_pending`, `o_drop_count`: 0.
  - All pointers: 0; FSM in `IDLE`.
- **Reset mid-frame.** Everything clears; partial and committed data are lost; `tvalid` drops asynchronously.
- **Cut-through latency.** With an empty buffer and output ready, a `tlast` handshake at edge N gives the first output byte `o_out_axis_tvalid` = 1 after edge N+3:
  - commit at N+1;
  - RAM read at N+2;
  - output register at N+3.
- **Back-to-back.** Back-to-back committed frames leave with no idle cycle between them.
- **Size boundaries.**
  - A frame of exactly DEPTH bytes is accepted into an empty buffer.
  - A frame of DEPTH+1 bytes is always dropped.
- **Overflow timing.** `o_overflow` pulses in the cycle after the rejected byte's handshake.
- **Freeing space.** Read-side frees become visible to the full check one cycle after the read.
- **Wrap-around.** Pointer wrap is transparent; data is correct across the RAM boundary.

## Structure
- Shared package `udp_buffer_pkg`:
  - typedef `axis_byte_t` = `{logic last; logic [7:0] data;}`;
  - write-FSM enum `wr_state_t` (`IDLE`, `FILL`, `DROP`).
- One sub-module, `sdp_ram`: parameters WIDTH and DEPTH; one write port, one registered read port; inferable as block RAM.
- The FSM, pointers, prefetch/skid and counters stay in the top module.

## Test plan
- Reset, then write 7-byte frame `3A 32 77 AB CD 12 34` (last on `34`), output ready → the same 7 bytes out, `tlast` on `34` only, first `tvalid` 3 cycles after the input `tlast`, `o_frames_pending` 1 then 0.
- Three 5-byte frames back-to-back with output `tready` = 0, then release → 15 bytes out contiguously in order, `o_frames_pending` shows 3 and counts down to 0.
- DEPTH=16: 10-byte frame (held), then 8-byte frame → second frame dropped, `o_overflow` pulses once, `o_drop_count` = 1; the next 6-byte frame is accepted once the first has drained.
- DEPTH=16: one 16-byte frame into an empty buffer → accepted. One 17-byte frame → dropped, count increments, nothing emitted.
- Random `i_out_axis_tready` toggling over 200 frames crossing the wrap point → byte-exact scoreboard match, data stable during stalls.
- Assert `i_rst_n` low mid-input and mid-output → all outputs 0 immediately; a subsequent 4-byte frame passes cleanly.

Source files
------------

// File: rtl/udp_buffer_pkg.sv
// Shared types for the UDP TX frame buffer: stored byte format and write-FSM states.
package udp_buffer_pkg;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } axis_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/udp_tx_frame_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (block-RAM style, no reset).
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_tx_frame_buffer.sv
// Store-and-forward byte FIFO: frames are released only once complete; overflowing frames
// are discarded whole and counted.
module udp_tx_frame_buffer
  import udp_buffer_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_in_axis_tdata,
  input  logic                    i_in_axis_tvalid,
  input  logic                    i_in_axis_tlast,
  output logic                    o_in_axis_tready,
  output logic [7:0]              o_out_axis_tdata,
  output logic                    o_out_axis_tvalid,
  output logic                    o_out_axis_tlast,
  input  logic                    i_out_axis_tready,
  output logic [$clog2(DEPTH):0]  o_frames_pending,
  output logic [DROP_CNT_W-1:0]   o_drop_count,
  output logic                    o_overflow,
  output wr_state_t               o_wr_state
);

  // Both AXI-Stream ports transfer a byte on a clock edge where tvalid and tready are
  // both 1; tvalid, tdata and tlast hold steady while tvalid is 1 and tready is 0.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wr_state_t     state, state_next;
  logic [PW-1:0] wr_ptr, commit_ptr, commit_vis, fetch_ptr, rd_ptr, used;
  logic          hs, full, do_write, do_commit, do_drop;
  axis_byte_t    wr_word, rd_word, sk0, sk1;
  logic [1:0]    sk_cnt;
  logic [2:0]    occ;
  logic          ram_valid, issue, pop, push, dec;

  assign hs      = i_in_axis_tvalid & o_in_axis_tready;
  // Space is reclaimed only when a byte leaves the output port, never on prefetch.
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == PW'(DEPTH));
  assign wr_word = {i_in_axis_tlast, i_in_axis_tdata};

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_commit  = 1'b0;
    do_drop    = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (hs) begin
          if (!full) begin
            do_write   = 1'b1;
            do_commit  = i_in_axis_tlast;
            state_next = i_in_axis_tlast ? IDLE : FILL;
          end else begin
            do_drop    = 1'b1;
            state_next = i_in_axis_tlast ? IDLE : DROP;
          end
        end
      end
      DROP: if (hs && i_in_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      commit_vis       <= '0;
      o_in_axis_tready <= 1'b0;
      o_overflow       <= 1'b0;
      o_drop_count     <= '0;
      o_frames_pending <= '0;
    end else begin
      state            <= state_next;
      o_in_axis_tready <= 1'b1;
      o_overflow       <= do_drop;
      // Commit is exposed to the read side one cycle late, giving the 3-cycle cut-through.
      commit_vis       <= commit_ptr;
      if (do_write)  wr_ptr     <= wr_ptr + PW'(1);
      if (do_drop)   wr_ptr     <= commit_ptr;
      if (do_commit) commit_ptr <= wr_ptr + PW'(1);
      if (do_drop && (o_drop_count != '1)) o_drop_count <= o_drop_count + DROP_CNT_W'(1);
      case ({do_commit, dec})
        2'b10:   o_frames_pending <= o_frames_pending + PW'(1);
        2'b01:   o_frames_pending <= o_frames_pending - PW'(1);
        default: ;
      endcase
    end
  end

  sdp_ram #(
    .WIDTH ($bits(axis_byte_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (do_write),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_word),
    .re    (issue),
    .raddr (fetch_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign o_out_axis_tvalid = (sk_cnt != 2'd0);
  assign o_out_axis_tdata  = sk0.data;
  assign o_out_axis_tlast  = sk0.last;
  assign pop  = o_out_axis_tvalid & i_out_axis_tready;
  assign push = ram_valid;
  assign dec  = pop & sk0.last;
  // A read is issued only if its data is guaranteed a skid slot when it arrives.
  assign occ   = {1'b0, sk_cnt} + {2'b00, ram_valid};
  assign issue = (fetch_ptr != commit_vis) && (occ <= ({2'b00, pop} + 3'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      sk0       <= '0;
      sk1       <= '0;
      sk_cnt    <= 2'd0;
    end else begin
      ram_valid <= issue;
      if (issue) fetch_ptr <= fetch_ptr + PW'(1);
      if (pop)   rd_ptr    <= rd_ptr + PW'(1);
      if (pop) begin
        if (sk_cnt == 2'd2) sk0 <= sk1;
        else if (push)      sk0 <= rd_word;
        if (push && (sk_cnt == 2'd2)) sk1 <= rd_word;
      end else if (push) begin
        if (sk_cnt == 2'd0) sk0 <= rd_word;
        else                sk1 <= rd_word;
      end
      sk_cnt <= sk_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign o_wr_state = state;

endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Directed bench for udp_tx_frame_buffer (DEPTH=16): latency, back-to-back, overflow drop,
// size boundaries, random back-pressure across wrap, and reset mid-frame.
module tb_udp_tx_frame_buffer;
  import udp_buffer_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_tdata = '0;
  logic       in_tvalid = 1'b0;
  logic       in_tlast = 1'b0;
  logic       in_tready;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tlast;
  logic       out_tready = 1'b0;
  logic [4:0] frames_pending;
  logic [15:0] drop_count;
  logic       overflow;
  wr_state_t  wr_state;

  initial forever #5 clk = ~clk;

  udp_tx_frame_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_in_axis_tdata   (in_tdata),
    .i_in_axis_tvalid  (in_tvalid),
    .i_in_axis_tlast   (in_tlast),
    .o_in_axis_tready  (in_tready),
    .o_out_axis_tdata  (out_tdata),
    .o_out_axis_tvalid (out_tvalid),
    .o_out_axis_tlast  (out_tlast),
    .i_out_axis_tready (out_tready),
    .o_frames_pending  (frames_pending),
    .o_drop_count      (drop_count),
    .o_overflow        (overflow),
    .o_wr_state        (wr_state)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         ovf_seen = 0;
  bit         rand_rdy = 1'b0;
  bit         stall_prev = 1'b0;
  logic [8:0] stall_word = '0;
  logic [7:0] f7 [0:6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Samples outputs at the negedge; a handshake seen here completes at the next posedge.
  task automatic sample();
    logic [8:0] w;
    if (!rst_n) return;
    if (overflow) ovf_seen++;
    if (stall_prev) begin
      check("hold_valid", 32'(out_tvalid), 32'd1);
      check("hold_data", 32'({out_tlast, out_tdata}), 32'(stall_word));
    end
    if (out_tvalid && out_tready) begin
      check("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("out_byte", 32'({out_tlast, out_tdata}), 32'(w));
      end
    end
    stall_prev = out_tvalid && !out_tready;
    stall_word = {out_tlast, out_tdata};
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    tick();
  endtask

  task automatic send_frame(input int len, input bit accept);
    logic [7:0] d;
    logic       l;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom_range(0, 255));
      l = (i == len - 1);
      if (accept) exp_q.push_back({l, d});
      send_byte(d, l);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || frames_pending != 0) && k < budget) begin
      tick();
      k++;
    end
    check({"drain_", tag}, 32'(k < budget), 32'd1);
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_tlast", 32'(out_tlast), 32'd0);
    check("rst_tdata", 32'(out_tdata), 32'd0);
    check("rst_tready", 32'(in_tready), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_pending", 32'(frames_pending), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_state", 32'(wr_state), 32'(IDLE));
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_tready_low", 32'(in_tready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_tready_high", 32'(in_tready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int len;
    int k;
    logic [7:0] d;
    f7 = '{8'h3A, 8'h32, 8'h77, 8'hAB, 8'hCD, 8'h12, 8'h34};
    @(posedge clk);
    #1;
    do_reset();

    // 7-byte frame, output ready: 3-cycle cut-through, exact bytes
    out_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({(i == 6), f7[i]});
      send_byte(f7[i], (i == 6));
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    check("t1_pending", 32'(frames_pending), 32'd1);
    cnt = 0;
    while (!out_tvalid && cnt < 10) begin
      tick();
      cnt++;
    end
    check("t1_latency", 32'(cnt), 32'd3);
    wait_drain("t1", 50);
    check("t1_pending_end", 32'(frames_pending), 32'd0);

    // Three 5-byte frames back-to-back while output stalled, then contiguous drain
    out_tready = 1'b0;
    send_frame(5, 1'b1);
    send_frame(5, 1'b1);
    send_frame(5, 1'b1);
    check("t2_pending3", 32'(frames_pending), 32'd3);
    repeat (4) tick();
    check("t2_held_valid", 32'(out_tvalid), 32'd1);
    out_tready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check("t2_contig", 32'(out_tvalid), 32'd1);
      tick();
      if ((i + 1) % 5 == 0) check("t2_countdown", 32'(frames_pending), 32'(3 - (i + 1) / 5));
    end
    wait_drain("t2", 20);

    // 10-byte frame held, 8-byte frame overflows and is dropped
    out_tready = 1'b0;
    send_frame(10, 1'b1);
    ovf_seen = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      send_byte(d, (i == 7));
      if (i == 6) check("t3_state_drop", 32'(wr_state), 32'(DROP));
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    check("t3_state_idle", 32'(wr_state), 32'(IDLE));
    repeat (3) tick();
    check("t3_ovf_once", 32'(ovf_seen), 32'd1);
    check("t3_drops", 32'(drop_count), 32'd1);
    check("t3_pending", 32'(frames_pending), 32'd1);
    out_tready = 1'b1;
    wait_drain("t3a", 60);
    send_frame(6, 1'b1);
    wait_drain("t3b", 60);
    check("t3_drops_after", 32'(drop_count), 32'd1);

    // Exactly DEPTH bytes accepted; DEPTH+1 bytes dropped with nothing emitted
    out_tready = 1'b0;
    send_frame(DEPTH, 1'b1);
    check("t4_full_pending", 32'(frames_pending), 32'd1);
    check("t4_full_drops", 32'(drop_count), 32'd1);
    out_tready = 1'b1;
    wait_drain("t4a", 80);
    ovf_seen = 0;
    send_frame(DEPTH + 1, 1'b0);
    repeat (6) tick();
    check("t4_over_tvalid", 32'(out_tvalid), 32'd0);
    check("t4_over_drops", 32'(drop_count), 32'd2);
    check("t4_over_ovf", 32'(ovf_seen), 32'd1);
    check("t4_over_pending", 32'(frames_pending), 32'd0);

    // 200 random frames with random back-pressure, crossing the wrap point many times
    rand_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 8);
      k = 0;
      while (exp_q.size() + len > DEPTH && k < 500) begin
        tick();
        k++;
      end
      check("t5_room", 32'(k < 500), 32'd1);
      send_frame(len, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;
    out_tready = 1'b1;
    wait_drain("t5", 200);
    check("t5_drops", 32'(drop_count), 32'd2);

    // Reset mid-input, then mid-output; a later 4-byte frame passes cleanly
    out_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i), 1'b0);
    do_reset();
    send_frame(6, 1'b1);
    repeat (5) tick();
    check("t6_out_active", 32'(out_tvalid), 32'd1);
    do_reset();
    send_frame(4, 1'b1);
    wait_drain("t6", 40);
    check("t6_pending", 32'(frames_pending), 32'd0);
    check("t6_drops", 32'(drop_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
